// File: rtl/fpu_sp_add_issue_if.sv
// Operand-in / result-out stream bundle for fpu_sp_add_issue.
// master = producer/consumer side, slave = the issue stage itself.
interface fpu_sp_add_issue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/fpu_sp_add_issue.sv
// Operand FIFO + issue FSM feeding fpu_sp_add, one op in flight, registered result.
// Optional adder watchdog: define FPU_ADD_ISSUE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a queued op and a free output register
// ISSUE   | dval high, operands held, waiting for rdy (or watchdog)
// RELEASE | dval low for one cycle so the adder sees it drop
module fpu_sp_add_issue #(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_sp_add_issue_if.slave io,
    output logic [31:0]       add_din1,
    output logic [31:0]       add_din2,
    output logic              add_dval,
    input  logic [31:0]       add_result,
    input  logic              add_rdy
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      fifo_a   [DEPTH];
    logic [31:0]      fifo_b   [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic push, pop, load_ops, capture, timeout_hit, out_free;
    logic             out_valid_q;
    logic [31:0]      out_result_q;
    logic [TAG_W-1:0] out_tag_q;

`ifdef FPU_ADD_ISSUE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;
`endif

    assign io.in_ready     = (count != FULL_CNT);
    assign push            = io.in_valid && io.in_ready;
    assign pop             = capture;
    assign out_free        = !out_valid_q || io.out_ready;
    assign add_dval        = (state == ISSUE);
    assign io.out_valid    = out_valid_q;
    assign io.out_result   = out_result_q;
    assign io.out_tag      = out_tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_ops    = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && out_free) begin
                    state_nxt = ISSUE;
                    load_ops  = 1'b1;
                end
            end
            ISSUE: begin
                if (add_rdy) begin
                    capture   = 1'b1;
                    state_nxt = RELEASE;
                end
`ifdef FPU_ADD_ISSUE_TIMEOUT_EN
                else if (tmr == '0) begin
                    capture     = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = RELEASE;
                end
`endif
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded in at push time by flipping b's sign bit only.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= io.in_a;
            fifo_b[wr_ptr]   <= {io.in_b[31] ^ io.in_sub, io.in_b[30:0]};
            fifo_tag[wr_ptr] <= io.in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_din1 <= '0;
            add_din2 <= '0;
        end else if (load_ops) begin
            add_din1 <= fifo_a[rd_ptr];
            add_din2 <= fifo_b[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (capture) begin
            out_valid_q  <= 1'b1;
            out_result_q <= timeout_hit ? QNAN : add_result;
            out_tag_q    <= fifo_tag[rd_ptr];
        end else if (out_valid_q && io.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

`ifdef FPU_ADD_ISSUE_TIMEOUT_EN
    logic out_err_q;

    // Down-counter: loaded on entry to ISSUE, expires at zero.
    always_ff @(posedge clk) begin
        if (!rst_n)                          tmr <= '0;
        else if (load_ops)                   tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        else if (state == ISSUE && tmr != '0) tmr <= tmr - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       out_err_q <= 1'b0;
        else if (capture) out_err_q <= timeout_hit;
    end

    assign io.out_err = out_err_q;
`else
    assign io.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_sp_add_issue.sv
// Self-checking bench for fpu_sp_add_issue with a behavioural adder stand-in.
module tb_fpu_sp_add_issue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpu_sp_add_issue_if #(.TAG_W(TAG_W)) io ();
    logic [31:0] add_din1, add_din2, add_result;
    logic        add_dval, add_rdy;

    fpu_sp_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (io),
        .add_din1   (add_din1),
        .add_din2   (add_din2),
        .add_dval   (add_dval),
        .add_result (add_result),
        .add_rdy    (add_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in adder: known sums for the directed operands, a fixed mix otherwise.
    function automatic logic [31:0] fake_add(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h4048_0000 && y == 32'h4000_0000) return 32'h40A4_0000;
        if (x == 32'h4048_0000 && y == 32'hC000_0000) return 32'h3F90_0000;
        return (x ^ {y[15:0], y[31:16]}) + 32'h0135_7913;
    endfunction

    function automatic logic [31:0] flip(input logic [31:0] b, input logic sub);
        return {b[31] ^ sub, b[30:0]};
    endfunction

    // Adder model: rdy pulses after mdl latency cycles of continuous dval.
    int          mdl_cnt = 0;
    int          mdl_lat_fixed = 5;
    int          mdl_lat_rand = 3;
    bit          mdl_never = 0, mdl_rand = 0, mdl_stray = 0;
    logic        mdl_rdy = 1'b0;
    logic        stray_bit = 1'b0;
    logic [31:0] mdl_res = '0;
    int          mdl_lat;
    assign mdl_lat = mdl_rand ? mdl_lat_rand : mdl_lat_fixed;

    always @(posedge clk) begin
        stray_bit <= 1'($urandom_range(0, 1));
        if (!add_dval) begin
            mdl_cnt <= 0;
            mdl_rdy <= 1'b0;
            mdl_lat_rand <= $urandom_range(1, 6);
        end else begin
            mdl_cnt <= mdl_cnt + 1;
            if (!mdl_never && mdl_cnt == mdl_lat - 1) begin
                mdl_rdy <= 1'b1;
                mdl_res <= fake_add(add_din1, add_din2);
            end else begin
                mdl_rdy <= 1'b0;
            end
        end
    end

    assign add_rdy    = mdl_rdy | (mdl_stray & ~add_dval & stray_bit);
    assign add_result = mdl_rdy ? mdl_res : 32'hDEAD_BEEF;

    task automatic test_reset();
        rst_n = 1'b0;
        io.in_valid = 0; io.in_a = '0; io.in_b = '0; io.in_sub = 0; io.in_tag = '0;
        io.out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", io.in_ready); end
        n_checks++; if (add_dval !== 1'b0) begin n_fail++; $display("FAIL reset_dval got=%b exp=0", add_dval); end
        n_checks++; if (add_din1 !== 32'h0 || add_din2 !== 32'h0) begin n_fail++; $display("FAIL reset_din got=%h/%h exp=0/0", add_din1, add_din2); end
        n_checks++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
        n_checks++; if (io.out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got=%h exp=0", io.out_result); end
        n_checks++; if (io.out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got=%h exp=0", io.out_tag); end
        n_checks++; if (io.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got=%b exp=0", io.out_err); end
    endtask

    task automatic test_single(input logic sub, input logic [TAG_W-1:0] tag,
                               input logic [31:0] exp_din2, input logic [31:0] exp_res);
        int lat, hold;
        bit unstable;
        io.out_ready = 1'b1;
        io.in_valid = 1'b1; io.in_a = 32'h4048_0000; io.in_b = 32'h4000_0000;
        io.in_sub = sub; io.in_tag = tag;
        @(negedge clk);
        io.in_valid = 1'b0;
        lat = 1;
        while (!add_dval && lat < 20) begin @(negedge clk); lat++; end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_issue_latency got=%0d exp=2", lat); end
        n_checks++; if (add_din1 !== 32'h4048_0000) begin n_fail++; $display("FAIL single_din1 got=%h exp=40480000", add_din1); end
        n_checks++; if (add_din2 !== exp_din2) begin n_fail++; $display("FAIL single_din2 got=%h exp=%h", add_din2, exp_din2); end
        hold = 0; unstable = 0;
        while (add_dval && hold < 100) begin
            if (add_din1 !== 32'h4048_0000 || add_din2 !== exp_din2) unstable = 1;
            @(negedge clk); hold++;
        end
        n_checks++; if (unstable) begin n_fail++; $display("FAIL single_din_stable got=unstable exp=stable"); end
        n_checks++; if (hold != mdl_lat_fixed + 1) begin n_fail++; $display("FAIL single_dval_width got=%0d exp=%0d", hold, mdl_lat_fixed + 1); end
        n_checks++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", io.out_valid); end
        n_checks++; if (io.out_result !== exp_res) begin n_fail++; $display("FAIL single_result got=%h exp=%h", io.out_result, exp_res); end
        n_checks++; if (io.out_tag !== tag) begin n_fail++; $display("FAIL single_tag got=%h exp=%h", io.out_tag, tag); end
        n_checks++; if (io.out_err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", io.out_err); end
        @(negedge clk);
        n_checks++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed got=%b exp=0", io.out_valid); end
    endtask

    task automatic test_back_to_back();
        localparam int N = DEPTH + 1;
        logic [31:0]      a_arr [N];
        logic [31:0]      b_arr [N];
        logic             s_arr [N];
        logic [TAG_W-1:0] t_arr [N];
        int pushed = 0, retired = 0, issued = 0, cyc = 0, last_rise = -1;
        bit drv_ok = 0, prev_dval = 0, saw_full = 0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = $urandom; b_arr[i] = $urandom;
            s_arr[i] = i[0]; t_arr[i] = TAG_W'(i + 2);
        end
        io.out_ready = 1'b1;
        while (retired < N && cyc < 300) begin
            if (drv_ok) pushed++;
            if (io.out_valid) begin
                n_checks++;
                if (retired >= N || io.out_result !== fake_add(a_arr[retired], flip(b_arr[retired], s_arr[retired]))
                    || io.out_tag !== t_arr[retired]) begin
                    n_fail++; $display("FAIL b2b_result idx=%0d got=%h/%h", retired, io.out_result, io.out_tag);
                end
                retired++;
            end
            n_checks++;
            if (io.in_ready !== ((pushed - retired) != DEPTH)) begin
                n_fail++; $display("FAIL b2b_in_ready got=%b exp=%b", io.in_ready, (pushed - retired) != DEPTH);
            end
            if (!io.in_ready) saw_full = 1;
            if (add_dval && !prev_dval) begin
                if (last_rise >= 0) begin
                    n_checks++;
                    if (cyc - last_rise != mdl_lat_fixed + 3) begin
                        n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - last_rise, mdl_lat_fixed + 3);
                    end
                end
                n_checks++;
                if (issued >= N || add_din1 !== a_arr[issued] || add_din2 !== flip(b_arr[issued], s_arr[issued])) begin
                    n_fail++; $display("FAIL b2b_issue idx=%0d got=%h/%h", issued, add_din1, add_din2);
                end
                issued++; last_rise = cyc;
            end
            prev_dval = add_dval;
            if (pushed < N) begin
                io.in_valid = 1'b1; io.in_a = a_arr[pushed]; io.in_b = b_arr[pushed];
                io.in_sub = s_arr[pushed]; io.in_tag = t_arr[pushed];
            end else begin
                io.in_valid = 1'b0;
            end
            drv_ok = io.in_valid && io.in_ready;
            @(negedge clk); cyc++;
        end
        io.in_valid = 1'b0;
        n_checks++; if (!saw_full) begin n_fail++; $display("FAIL b2b_full got=never_full exp=in_ready_low"); end
        n_checks++; if (retired != N) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", retired, N); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, b0, a1, b1, r0, r1;
        int n;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        r0 = fake_add(a0, b0); r1 = fake_add(a1, flip(b1, 1'b1));
        io.out_ready = 1'b0;
        io.in_valid = 1'b1; io.in_a = a0; io.in_b = b0; io.in_sub = 0; io.in_tag = 4'd7;
        @(negedge clk);
        io.in_a = a1; io.in_b = b1; io.in_sub = 1; io.in_tag = 4'd8;
        @(negedge clk);
        io.in_valid = 1'b0;
        n = 0;
        while (!io.out_valid && n < 50) begin @(negedge clk); n++; end
        n_checks++; if (io.out_valid !== 1'b1 || io.out_result !== r0 || io.out_tag !== 4'd7) begin
            n_fail++; $display("FAIL bp_first got=%b/%h/%h exp=1/%h/7", io.out_valid, io.out_result, io.out_tag, r0);
        end
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (io.out_valid !== 1'b1 || io.out_result !== r0 || io.out_tag !== 4'd7 || add_dval !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold got=%b/%h/%h dval=%b exp=1/%h/7 dval=0", io.out_valid, io.out_result, io.out_tag, add_dval, r0);
            end
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        n_checks++; if (io.out_valid !== 1'b0 || add_dval !== 1'b1 || add_din1 !== a1) begin
            n_fail++; $display("FAIL bp_release got=%b/%b/%h exp=0/1/%h", io.out_valid, add_dval, add_din1, a1);
        end
        n = 0;
        while (!io.out_valid && n < 50) begin @(negedge clk); n++; end
        n_checks++; if (io.out_valid !== 1'b1 || io.out_result !== r1 || io.out_tag !== 4'd8) begin
            n_fail++; $display("FAIL bp_second got=%b/%h/%h exp=1/%h/8", io.out_valid, io.out_result, io.out_tag, r1);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit leaked;
        io.out_ready = 1'b1;
        io.in_valid = 1'b1; io.in_a = $urandom; io.in_b = $urandom; io.in_sub = 0; io.in_tag = 4'd9;
        @(negedge clk);
        io.in_valid = 1'b0;
        n = 0;
        while (!add_dval && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        n_checks++; if (add_dval !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_issue got=%b exp=1", add_dval); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (add_dval !== 1'b0) begin n_fail++; $display("FAIL rstmid_dval got=%b exp=0", add_dval); end
        n_checks++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", io.out_valid); end
        n_checks++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", io.in_ready); end
        leaked = 0;
        repeat (20) begin
            @(negedge clk);
            if (io.out_valid !== 1'b0 || add_dval !== 1'b0) leaked = 1;
        end
        n_checks++; if (leaked) begin n_fail++; $display("FAIL rstmid_aborted got=activity exp=quiet"); end
    endtask

`ifdef FPU_ADD_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] a1, b1;
        int n;
        a1 = $urandom; b1 = $urandom;
        mdl_never = 1; mdl_lat_fixed = 7;
        io.out_ready = 1'b1;
        io.in_valid = 1'b1; io.in_a = $urandom; io.in_b = $urandom; io.in_sub = 0; io.in_tag = 4'd10;
        @(negedge clk);
        io.in_a = a1; io.in_b = b1; io.in_sub = 0; io.in_tag = 4'd11;
        @(negedge clk);
        io.in_valid = 1'b0;
        n = 0;
        while (!add_dval && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (add_dval && n < 100) begin n++; @(negedge clk); end
        mdl_never = 0;
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=8", n); end
        n_checks++; if (io.out_valid !== 1'b1 || io.out_result !== 32'h7FC0_0000) begin
            n_fail++; $display("FAIL timeout_result got=%b/%h exp=1/7fc00000", io.out_valid, io.out_result);
        end
        n_checks++; if (io.out_err !== 1'b1 || io.out_tag !== 4'd10) begin
            n_fail++; $display("FAIL timeout_err_tag got=%b/%h exp=1/a", io.out_err, io.out_tag);
        end
        n = 0;
        while (!add_dval && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (add_dval && n < 100) begin n++; @(negedge clk); end
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL timeout_rdy_wins_cycles got=%0d exp=8", n); end
        n_checks++; if (io.out_valid !== 1'b1 || io.out_result !== fake_add(a1, b1) || io.out_err !== 1'b0 || io.out_tag !== 4'd11) begin
            n_fail++; $display("FAIL timeout_rdy_wins got=%b/%h/%b/%h exp=1/%h/0/b", io.out_valid, io.out_result, io.out_err, io.out_tag, fake_add(a1, b1));
        end
        mdl_lat_fixed = 5;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        localparam int N = 40;
        logic [31:0]      q_a [$];
        logic [31:0]      q_b [$];
        logic [TAG_W-1:0] q_tag [$];
        logic [31:0]      q_res [$];
        logic [TAG_W-1:0] q_otag [$];
        logic [31:0]      last_res;
        logic [TAG_W-1:0] last_tag;
        int sent = 0, got = 0, cyc = 0;
        bit prev_dval = 0, held = 0;
        mdl_rand = 1; mdl_stray = 1;
        last_res = '0; last_tag = '0;
        while (got < N && cyc < 4000) begin
            if (add_dval && !prev_dval) begin
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL rand_issue_unexpected got=%h/%h", add_din1, add_din2);
                end else begin
                    if (add_din1 !== q_a[0] || add_din2 !== q_b[0] || io.out_valid !== 1'b0) begin
                        n_fail++; $display("FAIL rand_issue got=%h/%h ov=%b exp=%h/%h ov=0", add_din1, add_din2, io.out_valid, q_a[0], q_b[0]);
                    end
                    q_res.push_back(fake_add(q_a[0], q_b[0]));
                    q_otag.push_back(q_tag[0]);
                    void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_tag.pop_front());
                end
            end
            prev_dval = add_dval;
            if (io.out_valid) begin
                n_checks++;
                if (!held) begin
                    if (q_res.size() == 0) begin
                        n_fail++; $display("FAIL rand_out_unexpected got=%h", io.out_result);
                    end else begin
                        if (io.out_result !== q_res[0] || io.out_tag !== q_otag[0] || io.out_err !== 1'b0) begin
                            n_fail++; $display("FAIL rand_out got=%h/%h/%b exp=%h/%h/0", io.out_result, io.out_tag, io.out_err, q_res[0], q_otag[0]);
                        end
                        last_res = q_res[0]; last_tag = q_otag[0];
                        void'(q_res.pop_front()); void'(q_otag.pop_front());
                    end
                    held = 1; got++;
                end else if (io.out_result !== last_res || io.out_tag !== last_tag) begin
                    n_fail++; $display("FAIL rand_out_stable got=%h/%h exp=%h/%h", io.out_result, io.out_tag, last_res, last_tag);
                end
            end
            if (sent < N && $urandom_range(0, 2) != 0) begin
                io.in_valid = 1'b1; io.in_a = $urandom; io.in_b = $urandom;
                io.in_sub = 1'($urandom_range(0, 1)); io.in_tag = TAG_W'($urandom);
            end else begin
                io.in_valid = 1'b0;
            end
            if (io.in_valid && io.in_ready) begin
                q_a.push_back(io.in_a); q_b.push_back(flip(io.in_b, io.in_sub)); q_tag.push_back(io.in_tag);
                sent++;
            end
            io.out_ready = 1'($urandom_range(0, 1));
            if (io.out_valid && io.out_ready) held = 0;
            @(negedge clk); cyc++;
        end
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        mdl_rand = 0; mdl_stray = 0;
        n_checks++; if (got != N) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got, N); end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single(1'b0, 4'd1, 32'h4000_0000, 32'h40A4_0000);
        test_single(1'b1, 4'd1, 32'hC000_0000, 32'h3F90_0000);
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef FPU_ADD_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
